// File: rtl/mem_stage_ctrl_if.sv
// Signal bundle between EX/MEM, data_memory, MEM/WB and the memory-stage controller.
interface mem_stage_ctrl_if;
    logic        ex_valid;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_jump_mem;
    logic        ex_reg_write;
    logic [5:0]  ex_rd;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_ready;
    logic [31:0] dm_address;
    logic [31:0] dm_in;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_out;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [5:0]  wb_rd;
    logic [31:0] wb_data;
    logic        jump_valid;
    logic [31:0] jump_target;
    logic        err;

    modport master (
        output ex_valid, ex_mem_read, ex_mem_write, ex_jump_mem, ex_reg_write,
               ex_rd, ex_addr, ex_wdata, dm_out,
        input  ex_ready, dm_address, dm_in, dm_read, dm_write,
               wb_valid, wb_reg_write, wb_rd, wb_data, jump_valid, jump_target, err
    );

    modport slave (
        input  ex_valid, ex_mem_read, ex_mem_write, ex_jump_mem, ex_reg_write,
               ex_rd, ex_addr, ex_wdata, dm_out,
        output ex_ready, dm_address, dm_in, dm_read, dm_write,
               wb_valid, wb_reg_write, wb_rd, wb_data, jump_valid, jump_target, err
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues data_memory strobes, hides the one-cycle read
// latency with a two-state FSM, range-checks addresses and feeds MEM/WB and JM targets.
module mem_stage_ctrl #(
    parameter int ADDR_BITS = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    mem_stage_ctrl_if.slave    bus
);
    // state   | meaning
    // IDLE    | accepting requests, ex_ready high
    // RD_WAIT | load/JM issued, waiting one cycle for registered dm_out
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic        w_ready;
    logic        w_accept;
    logic        w_is_rd;
    logic        w_in_range;
    logic        w_multi_flag;
    logic        w_any_mem;
    logic        w_dm_read;
    logic        w_dm_write;
    logic        w_set_err;

    logic        r_rd_reg_write;
    logic [5:0]  r_rd_dest;
    logic        r_rd_is_jm;
    logic        r_rd_in_range;

    logic        r_wb_valid;
    logic        r_wb_reg_write;
    logic [5:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_jump_valid;
    logic [31:0] r_jump_target;
    logic        r_err;

    assign w_is_rd      = bus.ex_mem_read | bus.ex_jump_mem;
    assign w_in_range   = (bus.ex_addr[31:ADDR_BITS] == '0);
    assign w_any_mem    = w_is_rd | bus.ex_mem_write;
    assign w_multi_flag = (bus.ex_mem_read & bus.ex_mem_write)
                        | (bus.ex_mem_read & bus.ex_jump_mem)
                        | (bus.ex_mem_write & bus.ex_jump_mem);

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_accept     = 1'b0;
        w_dm_read    = 1'b0;
        w_dm_write   = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            IDLE: begin
                // the synchronous reset also blocks acceptance while it is held
                w_ready    = ~i_reset;
                w_accept   = bus.ex_valid & w_ready;
                w_dm_read  = w_accept & w_is_rd & w_in_range;
                w_dm_write = w_accept & bus.ex_mem_write & ~w_is_rd & w_in_range;
                w_set_err  = w_accept & (w_multi_flag | (w_any_mem & ~w_in_range));
                if (w_accept && w_is_rd) begin
                    w_next_state = RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_rd_reg_write <= 1'b0;
            r_rd_dest      <= '0;
            r_rd_is_jm     <= 1'b0;
            r_rd_in_range  <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_jump_valid   <= 1'b0;
            r_jump_target  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_wb_valid   <= 1'b0;
            r_jump_valid <= 1'b0;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                if (w_is_rd) begin
                    r_rd_reg_write <= bus.ex_reg_write;
                    r_rd_dest      <= bus.ex_rd;
                    r_rd_is_jm     <= bus.ex_jump_mem;
                    r_rd_in_range  <= w_in_range;
                end else begin
                    r_wb_valid     <= 1'b1;
                    r_wb_rd        <= bus.ex_rd;
                    r_wb_reg_write <= bus.ex_mem_write ? 1'b0 : bus.ex_reg_write;
                    r_wb_data      <= bus.ex_mem_write ? 32'd0 : bus.ex_addr;
                end
            end
            if (r_state == RD_WAIT) begin
                if (r_rd_is_jm) begin
                    r_jump_valid  <= 1'b1;
                    r_jump_target <= r_rd_in_range ? bus.dm_out : 32'd0;
                end else begin
                    r_wb_valid     <= 1'b1;
                    r_wb_rd        <= r_rd_dest;
                    r_wb_reg_write <= r_rd_reg_write;
                    r_wb_data      <= r_rd_in_range ? bus.dm_out : 32'd0;
                end
            end
        end
    end

    assign bus.ex_ready     = w_ready;
    assign bus.dm_address   = bus.ex_addr;
    assign bus.dm_in        = bus.ex_wdata;
    assign bus.dm_read      = w_dm_read;
    assign bus.dm_write     = w_dm_write;
    assign bus.wb_valid     = r_wb_valid;
    assign bus.wb_reg_write = r_wb_reg_write & r_wb_valid;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.jump_valid   = r_jump_valid;
    assign bus.jump_target  = r_jump_target;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a registered-read data_memory model.
module tb_mem_stage_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_stage_ctrl_if bus ();

    mem_stage_ctrl #(.ADDR_BITS(16)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data_memory model: write commits at the edge, read data appears the cycle after dm_read
    logic [31:0] mem     [0:65535];
    bit          written [0:65535];

    function automatic logic [31:0] init_val(input logic [15:0] a);
        case (a)
            16'd3:    return 32'd1024;
            16'd4:    return 32'd9;
            16'd2048: return 32'd60;
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.dm_write) begin
            mem[bus.dm_address[15:0]]     <= bus.dm_in;
            written[bus.dm_address[15:0]] <= 1'b1;
        end
        if (bus.dm_read) begin
            bus.dm_out <= written[bus.dm_address[15:0]] ? mem[bus.dm_address[15:0]]
                                                        : init_val(bus.dm_address[15:0]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic jm,
                         input logic rw, input logic [5:0] dst, input logic [31:0] addr,
                         input logic [31:0] wdata);
        bus.ex_valid     = v;
        bus.ex_mem_read  = rd;
        bus.ex_mem_write = wr;
        bus.ex_jump_mem  = jm;
        bus.ex_reg_write = rw;
        bus.ex_rd        = dst;
        bus.ex_addr      = addr;
        bus.ex_wdata     = wdata;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        bus.dm_out = 32'd0;
        rst        = 1'b1;
        idle();

        // reset: a presented load must not strobe or be accepted
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd1, 32'd3, 32'd0);
        chk("rst_dm_read", {31'd0, bus.dm_read}, 32'd0);
        chk("rst_ex_ready", {31'd0, bus.ex_ready}, 32'd0);
        tick();
        tick();
        chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_jump_target", bus.jump_target, 32'd0);
        rst = 1'b0;
        idle();
        chk("post_rst_ready", {31'd0, bus.ex_ready}, 32'd1);
        tick();

        // load addr 3 -> 1024 into r5
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 32'd3, 32'd0);
        chk("ld_dm_read_N", {31'd0, bus.dm_read}, 32'd1);
        chk("ld_dm_addr_N", bus.dm_address, 32'd3);
        tick();
        idle();
        chk("ld_ready_N1", {31'd0, bus.ex_ready}, 32'd0);
        chk("ld_dm_read_N1", {31'd0, bus.dm_read}, 32'd0);
        chk("ld_wb_valid_N1", {31'd0, bus.wb_valid}, 32'd0);
        tick();
        chk("ld_wb_valid_N2", {31'd0, bus.wb_valid}, 32'd1);
        chk("ld_wb_data_N2", bus.wb_data, 32'd1024);
        chk("ld_wb_rd_N2", {26'd0, bus.wb_rd}, 32'd5);
        chk("ld_wb_rw_N2", {31'd0, bus.wb_reg_write}, 32'd1);
        chk("ld_ready_N2", {31'd0, bus.ex_ready}, 32'd1);
        tick();
        chk("ld_wb_valid_N3", {31'd0, bus.wb_valid}, 32'd0);
        chk("ld_wb_data_hold", bus.wb_data, 32'd1024);

        // store 77 to addr 10, then load addr 10 into r7
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd10, 32'd77);
        chk("st_dm_write_N", {31'd0, bus.dm_write}, 32'd1);
        chk("st_dm_in_N", bus.dm_in, 32'd77);
        tick();
        chk("st_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("st_wb_data", bus.wb_data, 32'd0);
        chk("st_wb_rw", {31'd0, bus.wb_reg_write}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd7, 32'd10, 32'd0);
        chk("stld_dm_write_N1", {31'd0, bus.dm_write}, 32'd0);
        chk("stld_dm_read_N1", {31'd0, bus.dm_read}, 32'd1);
        tick();
        idle();
        chk("stld_ready_N2", {31'd0, bus.ex_ready}, 32'd0);
        tick();
        chk("stld_wb_valid_N3", {31'd0, bus.wb_valid}, 32'd1);
        chk("stld_wb_data_N3", bus.wb_data, 32'd77);
        chk("stld_wb_rd_N3", {26'd0, bus.wb_rd}, 32'd7);

        // ALU op
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9, 32'h0000_DEAD, 32'd0);
        chk("alu_no_strobe", {30'd0, bus.dm_read, bus.dm_write}, 32'd0);
        tick();
        idle();
        chk("alu_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("alu_wb_data", bus.wb_data, 32'h0000_DEAD);
        chk("alu_wb_rd", {26'd0, bus.wb_rd}, 32'd9);
        chk("alu_err", {31'd0, bus.err}, 32'd0);

        // JM at 2048 -> target 60
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 32'd2048, 32'd0);
        chk("jm_dm_read", {31'd0, bus.dm_read}, 32'd1);
        tick();
        idle();
        chk("jm_jv_N1", {31'd0, bus.jump_valid}, 32'd0);
        tick();
        chk("jm_jump_valid", {31'd0, bus.jump_valid}, 32'd1);
        chk("jm_jump_target", bus.jump_target, 32'd60);
        chk("jm_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("jm_wb_data_hold", bus.wb_data, 32'h0000_DEAD);
        tick();
        chk("jm_jv_after", {31'd0, bus.jump_valid}, 32'd0);
        chk("jm_target_hold", bus.jump_target, 32'd60);

        // out-of-range load
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd3, 32'h0001_0000, 32'd0);
        chk("oor_dm_read", {31'd0, bus.dm_read}, 32'd0);
        chk("oor_ready", {31'd0, bus.ex_ready}, 32'd1);
        tick();
        idle();
        chk("oor_ready_N1", {31'd0, bus.ex_ready}, 32'd0);
        chk("oor_err_N1", {31'd0, bus.err}, 32'd1);
        tick();
        chk("oor_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("oor_wb_data", bus.wb_data, 32'd0);

        // gating: invalid request in IDLE does nothing; err remains sticky
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 6'd4, 32'd3, 32'd5);
        chk("gate_no_strobe", {30'd0, bus.dm_read, bus.dm_write}, 32'd0);
        tick();
        chk("gate_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("gate_jv", {31'd0, bus.jump_valid}, 32'd0);
        tick();
        chk("err_sticky", {31'd0, bus.err}, 32'd1);

        rst = 1'b1;
        idle();
        tick();
        chk("rst2_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        idle();

        // conflicting read+write at addr 4: read wins, err set
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'd2, 32'd4, 32'd123);
        chk("conf_dm_write", {31'd0, bus.dm_write}, 32'd0);
        chk("conf_dm_read", {31'd0, bus.dm_read}, 32'd1);
        tick();
        idle();
        chk("conf_err", {31'd0, bus.err}, 32'd1);
        tick();
        chk("conf_wb_valid", {31'd0, bus.wb_valid}, 32'd1);
        chk("conf_wb_data", bus.wb_data, 32'd9);

        // back-to-back loads held upstream: one accepted every two cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'd6, 32'd3, 32'd0);
        chk("b2b_read_0", {31'd0, bus.dm_read}, 32'd1);
        tick();
        chk("b2b_read_1", {31'd0, bus.dm_read}, 32'd0);
        chk("b2b_ready_1", {31'd0, bus.ex_ready}, 32'd0);
        tick();
        chk("b2b_read_2", {31'd0, bus.dm_read}, 32'd1);
        chk("b2b_wb_valid_2", {31'd0, bus.wb_valid}, 32'd1);
        chk("b2b_wb_data_2", bus.wb_data, 32'd1024);

        // reset asserted during RD_WAIT abandons the load
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("mid_ready_rst", {31'd0, bus.ex_ready}, 32'd0);
        tick();
        chk("mid_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
        chk("mid_jv", {31'd0, bus.jump_valid}, 32'd0);
        chk("mid_wb_data", bus.wb_data, 32'd0);
        chk("mid_wb_rd", {26'd0, bus.wb_rd}, 32'd0);
        chk("mid_err", {31'd0, bus.err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_ready_after", {31'd0, bus.ex_ready}, 32'd1);
        tick();
        chk("mid_wb_valid_after", {31'd0, bus.wb_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller between the EX/MEM pipeline register and `data_memory`. It turns EX/MEM requests into `data_memory` read/write strobes and absorbs the memory's one-cycle registered read latency with a two-state FSM, stalling upstream for one cycle per load. It also range-checks addresses and delivers results to the MEM/WB register: ALU results, load data, and jump-memory (JM) targets.

## Interface
- `ADDR_BITS`, 16, implemented word-address bits; `data_memory` holds 2^ADDR_BITS words.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `ex_valid`  in  1  EX/MEM holds a valid instruction.
- `ex_mem_read`  in  1  load.
- `ex_mem_write`  in  1  store.
- `ex_jump_mem`  in  1  JM: jump target read from memory.
- `ex_reg_write`  in  1  instruction writes the register file.
- `ex_rd`  in  6  destination register.
- `ex_addr`  in  32  ALU result: memory word address, or write-back value for non-memory ops.
- `ex_wdata`  in  32  store data.
- `ex_ready`  out  1  request accepted this cycle; EX/MEM advances only when high.
- `dm_address`  out  32  to `data_memory.address`.
- `dm_in`  out  32  to `data_memory.in`.
- `dm_read`  out  1  to `data_memory.read`.
- `dm_write`  out  1  to `data_memory.write`.
- `dm_out`  in  32  from `data_memory.out`; valid the cycle after `dm_read`.
- `wb_valid`  out  1  MEM/WB entry valid, one-cycle pulse.
- `wb_reg_write`  out  1  registered copy of `ex_reg_write`, qualified by `wb_valid`.
- `wb_rd`  out  6  registered destination.
- `wb_data`  out  32  write-back value.
- `jump_valid`  out  1  one-cycle pulse: `jump_target` is valid.
- `jump_target`  out  32  JM target.
- `err`  out  1  sticky error flag.

## Operation
- **States:**
  - IDLE: `ex_ready` = 1.
  - RD_WAIT: `ex_ready` = 0.
- **Accept:** a request is accepted when `ex_valid` & `ex_ready`.
- **Request decode (combinational, IDLE only):**
  - `dm_address` = `ex_addr`.
  - `dm_in` = `ex_wdata`.
  - `dm_read` = accept & (`ex_mem_read` | `ex_jump_mem`) & in_range.
  - `dm_write` = accept & `ex_mem_write` & !(`ex_mem_read` | `ex_jump_mem`) & in_range.
  - In RD_WAIT: `dm_read` = `dm_write` = 0.
- **in_range:** `ex_addr[31:ADDR_BITS]` == 0.
- **Priority:** read/JM beats write. Any accepted instruction that sets two or more of {`ex_mem_read`, `ex_mem_write`, `ex_jump_mem`} sets `err`. An out-of-range memory access also sets `err`. `err` clears only on `reset`.
- **Transitions:**
  - IDLE → RD_WAIT on an accepted load or JM, including out-of-range ones; the FSM path stays uniform.
  - RD_WAIT → IDLE unconditionally after one cycle.
- **Captured on an accepted load/JM:** `rd`, `reg_write`, is_jm, in_range.
- **Write-back, registered at the end of the cycle shown:**
  - Non-memory op accepted in cycle N: `wb_valid` = 1 in N+1, `wb_data` = `ex_addr`.
  - Store accepted in cycle N: `wb_valid` = 1 in N+1, `wb_reg_write` = 0, `wb_data` = 0.
  - Load: at the end of the RD_WAIT cycle, `wb_data` = in_range ? `dm_out` : 0, and `wb_valid` = 1 in N+2.
  - JM: `jump_valid` = 1 and `jump_target` = in_range ? `dm_out` : 0 in N+2; `wb_valid` = 0.
- **Hold behaviour:** `wb_*` and `jump_target` hold their last value when the valid pulses are low. `wb_valid` and `jump_valid` are 0 on any cycle with no completion.

## Timing
- **Reset:** on a rising edge with `reset` = 1, state = IDLE and `wb_valid`, `wb_reg_write`, `jump_valid`, `err` = 0. `wb_rd`, `wb_data`, `jump_target` = 0.
- **During reset:** `dm_read` = `dm_write` = 0 and `ex_ready` = 0.
- **Reset mid-load:** reset asserted while in RD_WAIT abandons the load; no `wb_valid` or `jump_valid` is produced afterwards.
- **Latency:**
  - ALU op / store: 1 cycle.
  - Load / JM: 2 cycles, with one bubble (`ex_ready` = 0 for exactly one cycle).
- **Throughput:**
  - Back-to-back loads: one every 2 cycles.
  - Store followed by load to the same address: the load returns the stored value, because the write commits at edge N and the read samples at edge N+1.
- **Gating:** `ex_valid` = 0 in IDLE produces no strobes and no completion. Inputs presented during RD_WAIT are ignored; upstream must hold them.

## Test plan
- **Load:** reset, then load `ex_addr` = 3, `ex_rd` = 5 with `data_memory[3]` = 1024 → `dm_read` pulses in N, `ex_ready` = 0 in N+1, `wb_valid` = 1 with `wb_data` = 1024 and `wb_rd` = 5 in N+2.
- **Store then load:** store 77 to address 10 at N, then load address 10 at N+1 → `dm_write` = 1 in N only, `wb_data` = 77 in N+3.
- **ALU op and JM:** ALU op with `ex_addr` = 0xDEAD → `wb_data` = 0xDEAD in N+1. JM at address 2048 with memory value 60 → `jump_valid` = 1 and `jump_target` = 60 in N+2, `wb_valid` = 0.
- **Out of range:** load `ex_addr` = 0x0001_0000 → no `dm_read`, `wb_data` = 0 in N+2, `err` = 1 and stays 1 until reset.
- **Conflicting flags:** `ex_mem_read` = `ex_mem_write` = 1 at address 4 → `dm_write` = 0, load returns 9, `err` = 1.
- **Reset mid-load:** `reset` asserted in N+1 of a load → no `wb_valid` in N+2, all outputs 0, `ex_ready` = 1 after reset deasserts.
